// File: rtl/bus_arbiter2.sv
// Two-master round-robin arbiter for one memory-mapped peripheral bus.
// Each access runs grant -> slave access -> response. A slave-ack timeout
// keeps a missing peripheral from hanging the requesting master.

// Invariant checks on the registered outputs. This module has no effect on the logic.
module bus_arbiter2_checker (
  input logic clk,
  input logic rst,
  input logic s_write,
  input logic s_read,
  input logic m0_ready,
  input logic m1_ready,
  input logic timeout_err,
  input logic busy
);

  // Sample the registered outputs on every edge while reset is not asserted.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(s_write && s_read))
        else $error("bus_arbiter2: s_write and s_read both asserted");
      assert (!(m0_ready && m1_ready))
        else $error("bus_arbiter2: both ready outputs asserted");
      assert (!timeout_err || m0_ready || m1_ready)
        else $error("bus_arbiter2: timeout_err without a ready pulse");
      assert (!(s_write || s_read) || busy)
        else $error("bus_arbiter2: strobe active while not busy");
    end
  end

endmodule

module bus_arbiter2 #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_write,
  input  logic        m0_read,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_dout,
  output logic [31:0] m0_din,
  output logic        m0_ready,
  input  logic        m1_write,
  input  logic        m1_read,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_dout,
  output logic [31:0] m1_din,
  output logic        m1_ready,
  output logic        s_write,
  output logic        s_read,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_ack,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Counter value on the last ACCESS cycle allowed before the abort.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;          // 0 = master 0, 1 = master 1
  logic        op_write_q, op_write_d;    // latched operation of the access
  logic        last_grant_q, last_grant_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        s_write_q, s_write_d;
  logic        s_read_q, s_read_d;
  logic [31:0] s_addr_q, s_addr_d;
  logic [31:0] s_wdata_q, s_wdata_d;
  logic [31:0] m0_din_q, m0_din_d;
  logic [31:0] m1_din_q, m1_din_d;
  logic        m0_ready_q, m0_ready_d;
  logic        m1_ready_q, m1_ready_d;
  logic        timeout_err_q, timeout_err_d;
  logic        busy_q, busy_d;

  logic        req0_s;
  logic        req1_s;
  logic        grant1_s;
  logic        sel_write_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic [31:0] resp_data_s;

  // Request decode and round-robin choice; ties go to the master that did not win last.
  always_comb begin
    req0_s   = m0_write | m0_read;
    req1_s   = m1_write | m1_read;
    grant1_s = 1'b0;
    if (req0_s && req1_s) begin
      grant1_s = ~last_grant_q;
    end else if (req1_s) begin
      grant1_s = 1'b1;
    end else begin
      grant1_s = 1'b0;
    end
    // A write wins over a simultaneous read on the same master.
    if (grant1_s) begin
      sel_write_s = m1_write;
      sel_addr_s  = m1_addr;
      sel_wdata_s = m1_dout;
    end else begin
      sel_write_s = m0_write;
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_dout;
    end
    // An ack on the timeout boundary still returns slave data.
    if (s_ack) begin
      resp_data_s = s_rdata;
    end else begin
      resp_data_s = ERR_DATA;
    end
  end

  // Next-state and next-output logic of the access sequencer.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    op_write_d    = op_write_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    s_write_d     = s_write_q;
    s_read_d      = s_read_q;
    s_addr_d      = s_addr_q;
    s_wdata_d     = s_wdata_q;
    m0_din_d      = m0_din_q;
    m1_din_d      = m1_din_q;
    m0_ready_d    = 1'b0;
    m1_ready_d    = 1'b0;
    timeout_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req0_s || req1_s) begin
          state_d    = ST_ACCESS;
          owner_d    = grant1_s;
          op_write_d = sel_write_s;
          s_addr_d   = sel_addr_s;
          s_wdata_d  = sel_wdata_s;
          s_write_d  = sel_write_s;
          s_read_d   = ~sel_write_s;
          cnt_d      = 8'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        if (s_ack || (cnt_q == TMO_LAST)) begin
          state_d       = ST_RESP;
          s_write_d     = 1'b0;
          s_read_d      = 1'b0;
          timeout_err_d = ~s_ack;
          // Ready and read data are loaded now so they appear during RESP.
          if (owner_q) begin
            m1_ready_d = 1'b1;
            if (!op_write_q) begin
              m1_din_d = resp_data_s;
            end else begin
              m1_din_d = m1_din_q;
            end
          end else begin
            m0_ready_d = 1'b1;
            if (!op_write_q) begin
              m0_din_d = resp_data_s;
            end else begin
              m0_din_d = m0_din_q;
            end
          end
        end else begin
          state_d = ST_ACCESS;
          cnt_d   = cnt_q + 8'd1;
        end
      end

      ST_RESP: begin
        state_d      = ST_IDLE;
        last_grant_d = owner_q;
        cnt_d        = 8'd0;
      end

      default: begin
        state_d   = ST_IDLE;
        s_write_d = 1'b0;
        s_read_d  = 1'b0;
        cnt_d     = 8'd0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops any in-flight access at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      owner_q       <= 1'b0;
      op_write_q    <= 1'b0;
      last_grant_q  <= 1'b1;
      cnt_q         <= 8'd0;
      s_write_q     <= 1'b0;
      s_read_q      <= 1'b0;
      s_addr_q      <= 32'd0;
      s_wdata_q     <= 32'd0;
      m0_din_q      <= 32'd0;
      m1_din_q      <= 32'd0;
      m0_ready_q    <= 1'b0;
      m1_ready_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      op_write_q    <= op_write_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      s_write_q     <= s_write_d;
      s_read_q      <= s_read_d;
      s_addr_q      <= s_addr_d;
      s_wdata_q     <= s_wdata_d;
      m0_din_q      <= m0_din_d;
      m1_din_q      <= m1_din_d;
      m0_ready_q    <= m0_ready_d;
      m1_ready_q    <= m1_ready_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
    end
  end

  assign s_write     = s_write_q;
  assign s_read      = s_read_q;
  assign s_addr      = s_addr_q;
  assign s_wdata     = s_wdata_q;
  assign m0_din      = m0_din_q;
  assign m1_din      = m1_din_q;
  assign m0_ready    = m0_ready_q;
  assign m1_ready    = m1_ready_q;
  assign timeout_err = timeout_err_q;
  assign busy        = busy_q;

  bus_arbiter2_checker u_checker (
    .clk         (clk),
    .rst         (rst),
    .s_write     (s_write_q),
    .s_read      (s_read_q),
    .m0_ready    (m0_ready_q),
    .m1_ready    (m1_ready_q),
    .timeout_err (timeout_err_q),
    .busy        (busy_q)
  );

endmodule

// File: tb/tb_bus_arbiter2.sv
// Directed bench for bus_arbiter2: read, write, tie rotation, timeout,
// ack on the timeout boundary, read+write priority and async reset.
module tb_bus_arbiter2;

  logic        clk;
  logic        rst;
  logic        m0_write, m0_read;
  logic [31:0] m0_addr, m0_dout, m0_din;
  logic        m0_ready;
  logic        m1_write, m1_read;
  logic [31:0] m1_addr, m1_dout, m1_din;
  logic        m1_ready;
  logic        s_write, s_read;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        s_ack;
  logic        busy, timeout_err;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] A0 = 32'h8000_0010;
  localparam logic [31:0] A1 = 32'h8000_0020;

  bus_arbiter2 #(.TIMEOUT_CYCLES(4), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst(rst),
    .m0_write(m0_write), .m0_read(m0_read), .m0_addr(m0_addr), .m0_dout(m0_dout),
    .m0_din(m0_din), .m0_ready(m0_ready),
    .m1_write(m1_write), .m1_read(m1_read), .m1_addr(m1_addr), .m1_dout(m1_dout),
    .m1_din(m1_din), .m1_ready(m1_ready),
    .s_write(s_write), .s_read(s_read), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack), .busy(busy), .timeout_err(timeout_err)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    m0_write = 1'b0; m0_read = 1'b0; m0_addr = 32'd0; m0_dout = 32'd0;
    m1_write = 1'b0; m1_read = 1'b0; m1_addr = 32'd0; m1_dout = 32'd0;
    s_rdata = 32'd0; s_ack = 1'b0;
    tick(); tick();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_s_read", s_read, 1'b0);
    chk1("rst_s_write", s_write, 1'b0);
    chk1("rst_m0_ready", m0_ready, 1'b0);
    chk1("rst_m1_ready", m1_ready, 1'b0);
    chk1("rst_timeout", timeout_err, 1'b0);
    chk32("rst_s_addr", s_addr, 32'd0);
    chk32("rst_s_wdata", s_wdata, 32'd0);
    chk32("rst_m0_din", m0_din, 32'd0);
    chk32("rst_m1_din", m1_din, 32'd0);
    rst = 1'b0;
    tick();
    chk1("idle_busy", busy, 1'b0);

    // Single read on m0, ack one cycle after s_read rises.
    m0_read = 1'b1; m0_addr = 32'h8000_0000; s_rdata = 32'h0000_0005;
    tick();
    chk1("rd_s_read1", s_read, 1'b1);
    chk1("rd_s_write", s_write, 1'b0);
    chk32("rd_s_addr", s_addr, 32'h8000_0000);
    chk1("rd_busy", busy, 1'b1);
    tick();
    chk1("rd_s_read2", s_read, 1'b1);
    chk1("rd_ready_early", m0_ready, 1'b0);
    s_ack = 1'b1;
    tick();
    chk1("rd_s_read_off", s_read, 1'b0);
    chk1("rd_m0_ready", m0_ready, 1'b1);
    chk32("rd_m0_din", m0_din, 32'h0000_0005);
    chk1("rd_m1_ready", m1_ready, 1'b0);
    chk1("rd_resp_busy", busy, 1'b1);
    m0_read = 1'b0; s_ack = 1'b0;
    tick();
    chk1("rd_ready_pulse", m0_ready, 1'b0);
    chk1("rd_idle_busy", busy, 1'b0);

    // Write on m1 with ack held high (ignored in IDLE).
    m1_write = 1'b1; m1_addr = 32'h8000_0000; m1_dout = 32'h0000_0003; s_ack = 1'b1;
    tick();
    chk1("wr_s_write", s_write, 1'b1);
    chk1("wr_s_read", s_read, 1'b0);
    chk32("wr_s_addr", s_addr, 32'h8000_0000);
    chk32("wr_s_wdata", s_wdata, 32'h0000_0003);
    tick();
    chk1("wr_m1_ready", m1_ready, 1'b1);
    chk1("wr_m0_ready", m0_ready, 1'b0);
    chk1("wr_strobe_off", s_write, 1'b0);
    chk32("wr_m1_din", m1_din, 32'd0);
    chk32("wr_m0_din", m0_din, 32'h0000_0005);
    m1_write = 1'b0; s_ack = 1'b0;
    tick();
    chk1("wr_ready_pulse", m1_ready, 1'b0);

    // Timeout: no ack, four ACCESS cycles then abort.
    m0_read = 1'b1; m0_addr = 32'h8000_0004;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1($sformatf("to_s_read_%0d", i), s_read, 1'b1);
      chk1($sformatf("to_err_%0d", i), timeout_err, 1'b0);
    end
    tick();
    chk1("to_s_read_off", s_read, 1'b0);
    chk1("to_err", timeout_err, 1'b1);
    chk1("to_m0_ready", m0_ready, 1'b1);
    chk32("to_m0_din", m0_din, 32'hDEAD_BEEF);
    m0_read = 1'b0;
    tick();
    chk1("to_err_pulse", timeout_err, 1'b0);
    chk1("to_idle_busy", busy, 1'b0);

    // Ack on the fourth ACCESS cycle beats the timeout.
    m0_read = 1'b1; s_rdata = 32'h0000_0077;
    tick(); tick(); tick(); tick();
    chk1("ta_s_read4", s_read, 1'b1);
    s_ack = 1'b1;
    tick();
    chk1("ta_err", timeout_err, 1'b0);
    chk1("ta_m0_ready", m0_ready, 1'b1);
    chk32("ta_m0_din", m0_din, 32'h0000_0077);
    m0_read = 1'b0; s_ack = 1'b0;
    tick();
    chk1("ta_idle_busy", busy, 1'b0);

    // Tie after reset: held requests rotate m0, m1, m0, m1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk32("tie_rst_din", m0_din, 32'd0);
    m0_read = 1'b1; m0_addr = A0;
    m1_write = 1'b1; m1_addr = A1; m1_dout = 32'h0000_00C3;
    s_rdata = 32'h0000_0011; s_ack = 1'b1;
    for (int r = 0; r < 4; r++) begin
      tick();
      if (r % 2 == 0) begin
        chk1($sformatf("tie_g%0d_read", r), s_read, 1'b1);
        chk32($sformatf("tie_g%0d_addr", r), s_addr, A0);
      end else begin
        chk1($sformatf("tie_g%0d_write", r), s_write, 1'b1);
        chk32($sformatf("tie_g%0d_addr", r), s_addr, A1);
      end
      tick();
      chk1($sformatf("tie_r%0d_m0", r), m0_ready, (r % 2 == 0));
      chk1($sformatf("tie_r%0d_m1", r), m1_ready, (r % 2 == 1));
      if (r < 3) begin
        tick();
        chk1($sformatf("tie_i%0d_busy", r), busy, 1'b0);
        chk1($sformatf("tie_i%0d_rdy", r), m0_ready | m1_ready, 1'b0);
      end
    end
    chk32("tie_m0_din", m0_din, 32'h0000_0011);
    m0_read = 1'b0; m1_write = 1'b0; s_ack = 1'b0;
    tick(); tick();

    // Read and write both high on m0: write only.
    m0_write = 1'b1; m0_read = 1'b1; m0_addr = 32'h8000_0008; m0_dout = 32'h0000_00AB;
    s_ack = 1'b1;
    tick();
    chk1("rw_s_write", s_write, 1'b1);
    chk1("rw_s_read", s_read, 1'b0);
    chk32("rw_s_wdata", s_wdata, 32'h0000_00AB);
    tick();
    chk1("rw_m0_ready", m0_ready, 1'b1);
    chk1("rw_s_read_resp", s_read, 1'b0);
    chk32("rw_m0_din", m0_din, 32'h0000_0011);
    m0_write = 1'b0; m0_read = 1'b0; s_ack = 1'b0;
    tick();

    // Async reset in the middle of an m1 access.
    m1_write = 1'b1; m1_addr = A1;
    tick();
    chk1("ar_s_write", s_write, 1'b1);
    chk1("ar_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("ar_s_write_off", s_write, 1'b0);
    chk1("ar_busy_off", busy, 1'b0);
    chk1("ar_m1_ready", m1_ready, 1'b0);
    m1_write = 1'b0;
    tick();
    chk1("ar_hold_ready", m1_ready, 1'b0);
    rst = 1'b0;
    m0_read = 1'b1; m0_addr = A0; m1_write = 1'b1; m1_addr = A1; s_ack = 1'b1;
    tick();
    chk1("ar_tie_read", s_read, 1'b1);
    chk32("ar_tie_addr", s_addr, A0);
    tick();
    chk1("ar_tie_m0_ready", m0_ready, 1'b1);
    chk1("ar_tie_m1_ready", m1_ready, 1'b0);
    m0_read = 1'b0; m1_write = 1'b0; s_ack = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter2.md
Name: bus_arbiter2

Overview:
- Two-requester round-robin arbiter sharing one memory-mapped peripheral bus, e.g. the LED/IO register space at 0x8000_0000, between the CPU (master 0) and a second master such as a debug or DMA engine (master 1).
- Sequences each access as grant -> slave access -> response.
- Adds a slave-ack timeout so a missing peripheral cannot hang a master.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in ACCESS without s_ack before the access is aborted (range 1..255).
- ERR_DATA, 32'hDEAD_BEEF: value returned on m*_din for a timed-out read.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- m0_write  in  1  master 0 write request.
- m0_read  in  1  master 0 read request.
- m0_addr  in  32  master 0 address.
- m0_dout  in  32  master 0 write data.
- m0_din  out  32  master 0 read data.
- m0_ready  out  1  master 0 access-complete pulse.
- m1_write, m1_read, m1_addr, m1_dout, m1_din, m1_ready: same as m0_*, for master 1.
- s_write  out  1  slave write strobe.
- s_read  out  1  slave read strobe.
- s_addr  out  32  slave address.
- s_wdata  out  32  slave write data.
- s_rdata  in  32  slave read data.
- s_ack  in  1  slave completion, sampled in ACCESS.
- busy  out  1  high while state != IDLE.
- timeout_err  out  1  one-cycle pulse when an access times out.

Behaviour:
- All outputs are registered. Reset (async assert) forces:
  - state = IDLE, all strobes/ready/timeout_err = 0, s_addr/s_wdata/m*_din = 0;
  - last_grant = 1, so master 0 wins the first tie;
  - timeout counter = 0.
- Reset mid-access aborts immediately: no ready is issued and the in-flight access is dropped.
- A request is m*_write | m*_read. Masters hold request, address and data stable until their m*_ready pulse. If write and read are both high, the access is a write.
- IDLE:
  - If no request, stay in IDLE.
  - If exactly one master requests, grant it.
  - If both request, grant the master != last_grant.
  - On grant in cycle N: latch owner, op, addr and wdata into s_*; assert s_write or s_read from cycle N+1; enter ACCESS.
- ACCESS:
  - s_* held constant; counter increments each cycle.
  - s_ack = 1: capture s_rdata (reads only), deassert strobes, enter RESP.
  - Else if counter reaches TIMEOUT_CYCLES-1: deassert strobes, load ERR_DATA (reads), pulse timeout_err, enter RESP.
  - If s_ack arrives in the same cycle as the timeout boundary, ack wins and there is no error.
- RESP (one cycle):
  - Owner's m*_ready = 1; owner's m*_din = captured data for reads, unchanged for writes.
  - The non-owner's m*_ready stays 0 and its m*_din is unchanged.
  - last_grant = owner; counter cleared; return to IDLE.
- Minimum access is 3 cycles from request seen in IDLE to ready: grant, ACCESS with ack, RESP.
- A master re-requesting right after ready is rearbitrated; if the other master is waiting, the other master wins.
- s_ack outside ACCESS is ignored.
- busy = 1 in ACCESS and RESP.

Test Plan:
- Single read: reset, release; m0_read=1, m0_addr=32'h8000_0000; slave acks 1 cycle after s_read rises with s_rdata=32'h5 -> s_read high 2 cycles (ack seen on the 2nd), m0_ready pulses 1 cycle, m0_din=32'h5, m1_ready stays 0.
- Write passthrough: m1_write=1, m1_addr=32'h8000_0000, m1_dout=32'h3; immediate ack -> s_write=1, s_addr/s_wdata match; m1_ready pulses; m1_din unchanged.
- Tie after reset: both masters request simultaneously, held, with immediate ack -> grant order m0, m1, m0, m1; each ready separated by one IDLE cycle.
- Timeout: TIMEOUT_CYCLES=4, m0_read with no ack -> s_read high 4 cycles, timeout_err pulses, m0_din=32'hDEAD_BEEF, then IDLE; an ack arriving on the 4th cycle instead returns slave data with no error.
- Async reset mid-ACCESS: assert rst between clock edges -> strobes, busy and ready fall immediately; after release the next tie grants m0.
- Read+write both high on m0 -> performs a write only; s_read never asserts.
